// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
//   opcode        : IR bits 31:26, driven by the datapath
//   pc_write ..   : every datapath control line, driven by the controller
//   state         : current controller state (debug)
//   retired       : instructions completed since reset
// Modports: master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_wr;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_wr, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, state, retired
  );

  modport slave (
    output opcode,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_wr, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (R-type, lw, sw, beq, j, addi).
// Inserts MEM_WAIT wait cycles for every synchronous memory read (FETCH, LW_READ) and
// counts retired instructions.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high; all outputs forced to 0 while asserted
//   ctrl  : master side of multicycle_control_if (opcode in, control lines out)
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  multicycle_control_if.master ctrl
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StLwRead   = 4'd3,
    StLwWb     = 4'd4,
    StSwWrite  = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBeq      = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpAddi  = 6'h08;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;

  localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

  state_e           state_q, state_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  ctrl_t            ctrl_q, ctrl_out;

  // Moore decode; evaluated on the next state so outputs can be registered.
  function automatic ctrl_t decode(input state_e st, input logic [2:0] wcnt);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = AluAdd;
        if (wcnt == WaitLast) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
        end
      end
      StDecode: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = AluAdd;
      end
      StMemAddr, StAddiExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = AluAdd;
      end
      StLwRead: c.i_or_d = 1'b1;
      StLwWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      StSwWrite: begin
        c.i_or_d = 1'b1;
        c.mem_wr = 1'b1;
      end
      StRExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = AluFunct;
      end
      StRWb: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      StAddiWb: c.reg_write = 1'b1;
      StBeq: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = AluSub;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      StIllegal: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    retire  = 1'b0;
    case (state_q)
      StFetch, StLwRead: begin
        if (wcnt_q == WaitLast) begin
          state_d = (state_q == StFetch) ? StDecode : StLwWb;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StDecode: begin
        case (ctrl.opcode)
          OpRType:    state_d = StRExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBeq;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default:    state_d = StIllegal;
        endcase
      end
      StMemAddr:  state_d = (ctrl.opcode == OpLw) ? StLwRead : StSwWrite;
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      StLwWb, StSwWrite, StRWb, StAddiWb, StBeq, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StIllegal:  state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StFetch;
      wcnt_q    <= '0;
      retired_q <= '0;
      ctrl_q    <= decode(StFetch, 3'd0);
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      retired_q <= retired_q + CNT_W'(retire);
      ctrl_q    <= decode(state_d, wcnt_d);
    end
  end

  // Gate with Reset combinationally so no strobe leaks out while reset is held.
  always_comb begin
    ctrl_out = Reset ? '0 : ctrl_q;
  end

  assign ctrl.pc_write      = ctrl_out.pc_write;
  assign ctrl.pc_write_cond = ctrl_out.pc_write_cond;
  assign ctrl.pc_source     = ctrl_out.pc_source;
  assign ctrl.i_or_d        = ctrl_out.i_or_d;
  assign ctrl.mem_wr        = ctrl_out.mem_wr;
  assign ctrl.ir_write      = ctrl_out.ir_write;
  assign ctrl.reg_dst       = ctrl_out.reg_dst;
  assign ctrl.mem_to_reg    = ctrl_out.mem_to_reg;
  assign ctrl.reg_write     = ctrl_out.reg_write;
  assign ctrl.alu_src_a     = ctrl_out.alu_src_a;
  assign ctrl.alu_src_b     = ctrl_out.alu_src_b;
  assign ctrl.alu_op        = ctrl_out.alu_op;
  assign ctrl.illegal       = ctrl_out.illegal;
  assign ctrl.state         = Reset ? 4'd0 : state_q;
  assign ctrl.retired       = Reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst0 = 1'b1;
  logic rst3 = 1'b1;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) if1 ();
  multicycle_control_if #(.CNT_W(4))  if0 ();
  multicycle_control_if #(.CNT_W(4))  if3 ();

  multicycle_control #(.MEM_WAIT(1), .CNT_W(32)) dut1 (.Clk(clk), .Reset(rst1), .ctrl(if1.master));
  multicycle_control #(.MEM_WAIT(0), .CNT_W(4))  dut0 (.Clk(clk), .Reset(rst0), .ctrl(if0.master));
  multicycle_control #(.MEM_WAIT(3), .CNT_W(4))  dut3 (.Clk(clk), .Reset(rst3), .ctrl(if3.master));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  // Packed control word: {pw, pwc, ps, iod, mw, irw, rd, m2r, rw, sa, sb, aop, ill}
  function automatic logic [16:0] mk(input logic pw, input logic pwc, input logic [1:0] ps,
                                     input logic iod, input logic mw, input logic irw,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [2:0] aop, input logic ill);
    return {pw, pwc, ps, iod, mw, irw, rd, m2r, rw, sa, sb, aop, ill};
  endfunction

  function automatic logic [16:0] act1();
    return mk(if1.pc_write, if1.pc_write_cond, if1.pc_source, if1.i_or_d, if1.mem_wr,
              if1.ir_write, if1.reg_dst, if1.mem_to_reg, if1.reg_write, if1.alu_src_a,
              if1.alu_src_b, if1.alu_op, if1.illegal);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [16:0] c_z, c_f0, c_f1, c_dec, c_mad, c_lwr, c_lwwb, c_sww, c_rex, c_rwb;
  logic [16:0] c_aex, c_awb, c_beq, c_jmp, c_ill;

  task automatic add(input logic rst, input logic [5:0] opc, input logic [3:0] st,
                     input logic [16:0] ctl, input logic [31:0] ret);
    vec_t v;
    v.rst = rst; v.opc = opc; v.st = st; v.ctl = ctl; v.ret = ret;
    vecs.push_back(v);
  endtask

  // Two FETCH cycles at MEM_WAIT=1 followed by DECODE.
  task automatic add_fd(input logic [5:0] opc, input logic [31:0] ret);
    add(1'b0, opc, 4'd0, c_f0, ret);
    add(1'b0, opc, 4'd0, c_f1, ret);
    add(1'b0, opc, 4'd1, c_dec, ret);
  endtask

  initial begin
    logic [5:0] opc_pool [8];
    logic [3:0] seq0 [4];
    logic [3:0] seq3 [7];

    c_z    = '0;
    c_f0   = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    c_f1   = mk(1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    c_dec  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 0);
    c_mad  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0);
    c_lwr  = mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    c_lwwb = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0);
    c_sww  = mk(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    c_rex  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
    c_rwb  = mk(0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 0);
    c_aex  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0);
    c_awb  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0);
    c_beq  = mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0);
    c_jmp  = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    c_ill  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);

    if1.opcode = 6'h00;
    if0.opcode = 6'h08;
    if3.opcode = 6'h08;

    // Cycle-by-cycle vectors for the MEM_WAIT=1 build.
    add(1'b1, 6'h00, 4'd0, c_z, 0);
    add(1'b1, 6'h00, 4'd0, c_z, 0);
    add_fd(6'h00, 0);                       // R-type
    add(1'b0, 6'h00, 4'd6, c_rex, 0);
    add(1'b0, 6'h00, 4'd7, c_rwb, 0);
    add_fd(6'h23, 1);                       // lw
    add(1'b0, 6'h23, 4'd2, c_mad, 1);
    add(1'b0, 6'h23, 4'd3, c_lwr, 1);
    add(1'b0, 6'h23, 4'd3, c_lwr, 1);
    add(1'b0, 6'h23, 4'd4, c_lwwb, 1);
    add_fd(6'h2B, 2);                       // sw
    add(1'b0, 6'h2B, 4'd2, c_mad, 2);
    add(1'b0, 6'h2B, 4'd5, c_sww, 2);
    add_fd(6'h04, 3);                       // beq
    add(1'b0, 6'h04, 4'd8, c_beq, 3);
    add_fd(6'h02, 4);                       // j
    add(1'b0, 6'h02, 4'd9, c_jmp, 4);
    add_fd(6'h3F, 5);                       // illegal
    add(1'b0, 6'h3F, 4'd12, c_ill, 5);
    add_fd(6'h08, 5);                       // addi
    add(1'b0, 6'h08, 4'd10, c_aex, 5);
    add(1'b0, 6'h08, 4'd11, c_awb, 5);
    add_fd(6'h23, 6);                       // lw abandoned by reset in LW_READ
    add(1'b0, 6'h23, 4'd2, c_mad, 6);
    add(1'b0, 6'h23, 4'd3, c_lwr, 6);
    add(1'b1, 6'h23, 4'd0, c_z, 0);
    add(1'b1, 6'h23, 4'd0, c_z, 0);
    add(1'b1, 6'h23, 4'd0, c_z, 0);
    add_fd(6'h00, 0);                       // fresh R-type after release
    add(1'b0, 6'h00, 4'd6, c_rex, 0);
    add(1'b0, 6'h00, 4'd7, c_rwb, 0);
    add(1'b0, 6'h00, 4'd0, c_f0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clk);
      rst1 = vecs[i].rst;
      if1.opcode = vecs[i].opc;
      e.idx = i; e.st = vecs[i].st; e.ctl = vecs[i].ctl; e.ret = vecs[i].ret;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d state", e.idx), 32'(if1.state), 32'(e.st));
      chk($sformatf("vec%0d ctrl", e.idx), 32'(act1()), 32'(e.ctl));
      chk($sformatf("vec%0d retired", e.idx), if1.retired, e.ret);
    end

    // Random opcodes: strobe exclusivity must hold every cycle.
    opc_pool = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if1.opcode = (i % 5 == 4) ? 6'($urandom) : opc_pool[$urandom_range(0, 7)];
      #1;
      chk("pc_write excl", 32'(if1.pc_write & if1.pc_write_cond), 0);
      chk("strobe excl", 32'(32'(if1.mem_wr) + 32'(if1.reg_write) + 32'(if1.ir_write) > 1), 0);
    end

    // addi loops on MEM_WAIT=0 and MEM_WAIT=3 builds with a 4-bit counter (wraps 15 -> 0).
    seq0 = '{4'd0, 4'd1, 4'd10, 4'd11};
    seq3 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd10, 4'd11};
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst0 = 1'b0;
        rst3 = 1'b0;
      end
      #1;
      chk($sformatf("mw0 c%0d state", k), 32'(if0.state), 32'(seq0[k % 4]));
      chk($sformatf("mw0 c%0d retired", k), 32'(if0.retired), 32'((k / 4) % 16));
      chk($sformatf("mw0 c%0d ir_write", k), 32'(if0.ir_write), 32'(k % 4 == 0));
      chk($sformatf("mw3 c%0d state", k), 32'(if3.state), 32'(seq3[k % 7]));
      chk($sformatf("mw3 c%0d retired", k), 32'(if3.retired), 32'((k / 7) % 16));
      chk($sformatf("mw3 c%0d ir_write", k), 32'(if3.ir_write), 32'(k % 7 == 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath, directly downstream of the instruction register: consumes the 6-bit opcode field (Instr31_26) and drives every datapath control line: PC load, memory address mux, memory write, IR load, register file, ALU operand muxes and ALU op class. Supports R-type, lw, sw, beq, j and addi, and inserts wait cycles for the synchronous-read memory. Also keeps a count of retired instructions.

Parameters:
MEM_WAIT, 1, extra cycles a memory read occupies beyond the first (read data valid MEM_WAIT cycles after address issue); legal 0..7
CNT_W, 32, width of the retired-instruction counter

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
opcode  in  6  IR bits 31:26; valid from DECODE onward
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
i_or_d  out  1  memory address mux: 0 PC, 1 ALUOut
mem_wr  out  1  memory write strobe
ir_write  out  1  IR load (Load_ir)
reg_dst  out  1  0 rt (20:16), 1 rd (15:11)
mem_to_reg  out  1  0 ALUOut, 1 MDR
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  3  000 ADD, 001 SUB, 010 use funct field
illegal  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state encoding (debug)
retired  out  CNT_W  instructions completed since reset

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, LW_READ 3, LW_WB 4, SW_WRITE 5, R_EXEC 6, R_WB 7, BEQ 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, ILLEGAL 12; 13-15 unreachable, decode to FETCH next cycle.
- Reset (sampled on Clk edge): state<=FETCH, wait counter<=0, retired<=0. While Reset=1 all control outputs forced 0 combinationally (no write strobe may fire during reset); state shows 0. Reset mid-instruction abandons it; no partial write strobe follows release.
- Unlisted outputs are 0 in every state. wait counter wcnt (3 bits) counts cycles spent in FETCH/LW_READ, cleared on exit.
- FETCH: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD. Held while wcnt<MEM_WAIT. On cycle wcnt==MEM_WAIT: ir_write=1, pc_write=1, pc_source=00, next DECODE. Total MEM_WAIT+1 cycles.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next by opcode: 0x00 R_EXEC, 0x23/0x2B MEM_ADDR, 0x04 BEQ, 0x02 JUMP, 0x08 ADDI_EXEC, other ILLEGAL. Opcode sampled only here.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next LW_READ if opcode 0x23, else SW_WRITE.
- LW_READ: i_or_d=1; MEM_WAIT+1 cycles as in FETCH, then LW_WB.
- LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- SW_WRITE: i_or_d=1, mem_wr=1, exactly one cycle -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB: reg_dst=1, reg_write=1 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD -> ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ILLEGAL: illegal=1 one cycle -> FETCH (instruction acts as nop; PC already advanced).
- retired increments by 1 on the edge leaving LW_WB, SW_WRITE, R_WB, ADDI_WB, BEQ, JUMP; not ILLEGAL. Wraps modulo 2^CNT_W.
- At most one of pc_write/pc_write_cond, and at most one of mem_wr/reg_write/ir_write, asserted in any cycle.
- Latency at MEM_WAIT=1 (cycles incl. fetch): R 5, addi 5, sw 5, lw 7, beq 4, j 4, illegal 4.

Test Plan:
- Reset held 3 cycles mid-LW_READ -> all outputs 0 during reset, state=0, retired=0; one cycle after release ir_write=0, second cycle ir_write=1, pc_write=1.
- opcode=0x00, MEM_WAIT=1 -> states 0,0,1,6,7,0; reg_write=1 with reg_dst=1 only in cycle 5; retired 0->1.
- opcode=0x23 -> 0,0,1,2,3,3,4; i_or_d=1 both LW_READ cycles; mem_to_reg=reg_write=1 in LW_WB; then 0x2B -> mem_wr=1 exactly one cycle, reg_write never.
- opcode=0x04 then 0x02 -> BEQ: pc_write_cond=1, pc_source=01, alu_op=001; JUMP: pc_write=1, pc_source=10; each 4 cycles, retired +2.
- opcode=0x3F -> illegal pulses once in state 12, retired unchanged, next state FETCH; rerun with MEM_WAIT=0 and 3: FETCH lasts 1 and 4 cycles.
- Preload retired to 2^CNT_W-1 (CNT_W=4 build: 15), retire one addi -> retired=0; invariant checker: no two write strobes concurrent over 10k random opcodes.
